hazard_resolve: RTL and testbench

//  Consumer side of the decode-stage hazard chain. Takes the final {conf, type} code from the

---
 rtl/hazard_resolve_pkg.sv | 26 ++
 rtl/hazard_resolve_fwd_sel_decode.sv | 36 +++
 rtl/hazard_resolve.sv | 126 ++++++++++++
 tb/tb_hazard_resolve.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/hazard_resolve_pkg.sv
// Shared definitions for the decode-stage hazard chain: hazard type codes,
// forwarding select encodings and the resolver FSM state encoding.
package hazard_resolve_pkg;

  // Hazard type codes produced by the distance-1/distance-2 detector cascade
  localparam logic [3:0] HZ_NONE      = 4'd0;
  localparam logic [3:0] HZ_D1_ALU_RS = 4'd1;
  localparam logic [3:0] HZ_D1_ALU_RT = 4'd2;
  localparam logic [3:0] HZ_D1_LD_RS  = 4'd3;
  localparam logic [3:0] HZ_D1_LD_RT  = 4'd4;
  localparam logic [3:0] HZ_D2_ALU_RS = 4'd5;
  localparam logic [3:0] HZ_D2_ALU_RT = 4'd6;
  localparam logic [3:0] HZ_D2_LD_RS  = 4'd7;
  localparam logic [3:0] HZ_D2_LD_RT  = 4'd8;

  // ID/EX operand select encodings
  localparam logic [1:0] FWD_REG = 2'b00;  // register file
  localparam logic [1:0] FWD_EXM = 2'b01;  // EX/MEM ALU result
  localparam logic [1:0] FWD_MWB = 2'b10;  // MEM/WB result

  typedef enum logic {
    ST_RUN      = 1'b0,
    ST_LU_STALL = 1'b1
  } hz_state_t;

endpackage

// File: rtl/hazard_resolve_fwd_sel_decode.sv
// Combinational decode of the detector's {conf, type} code into the next
// forwarding selects and the load-use indication.
module fwd_sel_decode
  import hazard_resolve_pkg::*;
(
  input  logic       hz_conf,
  input  logic [3:0] hz_type,
  output logic [1:0] next_a,
  output logic [1:0] next_b,
  output logic       is_lu,
  output logic       lu_rt
);

  // Map the hazard code to operand selects; unused codes and conf=0 mean no hazard
  always_comb begin
    next_a = FWD_REG;
    next_b = FWD_REG;
    is_lu  = 1'b0;
    lu_rt  = 1'b0;
    if (hz_conf) begin
      case (hz_type)
        HZ_D1_ALU_RS: next_a = FWD_EXM;
        HZ_D1_ALU_RT: next_b = FWD_EXM;
        HZ_D1_LD_RS:  is_lu  = 1'b1;
        HZ_D1_LD_RT: begin
          is_lu = 1'b1;
          lu_rt = 1'b1;
        end
        HZ_D2_ALU_RS, HZ_D2_LD_RS: next_a = FWD_MWB;
        HZ_D2_ALU_RT, HZ_D2_LD_RT: next_b = FWD_MWB;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/hazard_resolve.sv
// Hazard resolver: turns the final detector code into registered ID/EX
// forwarding selects and load-use stall/flush controls.
// Optional feature: define HZ_STALL_CNT_EN to build the saturating
// bubble-cycle statistics counter on stall_cnt; otherwise it reads 0.
// A load-use hazard yields LOAD_LAT bubble cycles in total: the detection
// cycle plus LOAD_LAT-1 cycles in LU_STALL. The last LU_STALL cycle
// (bub_cnt==0) is a release cycle with stalls and flush low, so the held
// instruction enters EX on the same edge its select is loaded with MEM/WB.
module hazard_resolve
  import hazard_resolve_pkg::*;
#(
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hz_hold,
  input  logic             hz_conf,
  input  logic [3:0]       hz_type,
  output logic [1:0]       fwd_a_sel,
  output logic [1:0]       fwd_b_sel,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_e,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [1:0] BUB_INIT = 2'(LOAD_LAT - 1);

  hz_state_t  state_reg;
  logic [1:0] bub_cnt_reg;
  logic       lu_rt_reg;
  logic [1:0] fwd_a_reg;
  logic [1:0] fwd_b_reg;

  logic [1:0] next_a;
  logic [1:0] next_b;
  logic       is_lu;
  logic       lu_rt;

  fwd_sel_decode u_dec (
    .hz_conf (hz_conf),
    .hz_type (hz_type),
    .next_a  (next_a),
    .next_b  (next_b),
    .is_lu   (is_lu),
    .lu_rt   (lu_rt)
  );

  // Stall/flush controls: combinational so the load-use bubble lands in the detection cycle
  always_comb begin
    stall_f = 1'b0;
    stall_d = 1'b0;
    flush_e = 1'b0;
    if (rst) begin
      stall_f = 1'b0;
    end else if (hz_hold) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
    end else if (state_reg == ST_RUN) begin
      stall_f = is_lu;
      stall_d = is_lu;
      flush_e = is_lu;
    end else if (bub_cnt_reg != 2'd0) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_e = 1'b1;
    end
  end

  // FSM, bubble counter, latched operand and registered forwarding selects
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= ST_RUN;
      bub_cnt_reg <= 2'd0;
      lu_rt_reg   <= 1'b0;
      fwd_a_reg   <= FWD_REG;
      fwd_b_reg   <= FWD_REG;
    end else if (!hz_hold) begin
      case (state_reg)
        ST_RUN: begin
          if (is_lu) begin
            state_reg   <= ST_LU_STALL;
            bub_cnt_reg <= BUB_INIT;
            lu_rt_reg   <= lu_rt;
            fwd_a_reg   <= FWD_REG;
            fwd_b_reg   <= FWD_REG;
          end else begin
            fwd_a_reg <= next_a;
            fwd_b_reg <= next_b;
          end
        end
        ST_LU_STALL: begin
          if (bub_cnt_reg != 2'd0) begin
            bub_cnt_reg <= bub_cnt_reg - 2'd1;
          end else begin
            state_reg <= ST_RUN;
            fwd_a_reg <= lu_rt_reg ? FWD_REG : FWD_MWB;
            fwd_b_reg <= lu_rt_reg ? FWD_MWB : FWD_REG;
          end
        end
      endcase
    end
  end

  assign fwd_a_sel = fwd_a_reg;
  assign fwd_b_sel = fwd_b_reg;

`ifdef HZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_reg;

  // Count inserted bubble cycles, saturating at all-ones
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_reg <= '0;
    end else if (flush_e && !hz_hold && (stall_cnt_reg != {CNT_W{1'b1}})) begin
      stall_cnt_reg <= stall_cnt_reg + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_reg;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_resolve.sv
// Scoreboard bench for hazard_resolve. Two instances share the stimulus:
// d1 (LOAD_LAT=1, CNT_W=16) and d3 (LOAD_LAT=3, CNT_W=4, so counter
// saturation is reachable). Each step pushes hand-computed expected outputs
// for the cycle; a negedge monitor pops and compares.
module tb_hazard_resolve;

  logic       clk = 1'b0;
  logic       rst;
  logic       hz_hold;
  logic       hz_conf;
  logic [3:0] hz_type;

  logic [1:0]  d1_fa, d1_fb, d3_fa, d3_fb;
  logic        d1_sf, d1_sd, d1_fe, d3_sf, d3_sd, d3_fe;
  logic [15:0] d1_cnt;
  logic [3:0]  d3_cnt;

  int checks = 0;
  int errors = 0;
  int step_no = 0;
  int m1 = 0;
  int m3 = 0;

  typedef struct {
    int         stp;
    logic [5:0] e1;  // {fa, fb, stall, flush}
    logic [5:0] e3;
    int         c1;
    int         c3;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  hazard_resolve #(.LOAD_LAT(1), .CNT_W(16)) d1 (
    .clk(clk), .rst(rst), .hz_hold(hz_hold), .hz_conf(hz_conf), .hz_type(hz_type),
    .fwd_a_sel(d1_fa), .fwd_b_sel(d1_fb), .stall_f(d1_sf), .stall_d(d1_sd),
    .flush_e(d1_fe), .stall_cnt(d1_cnt)
  );

  hazard_resolve #(.LOAD_LAT(3), .CNT_W(4)) d3 (
    .clk(clk), .rst(rst), .hz_hold(hz_hold), .hz_conf(hz_conf), .hz_type(hz_type),
    .fwd_a_sel(d3_fa), .fwd_b_sel(d3_fb), .stall_f(d3_sf), .stall_d(d3_sd),
    .flush_e(d3_fe), .stall_cnt(d3_cnt)
  );

  task automatic chk(input string nm, input int stp, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d got %0h expected %0h", nm, stp, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue that cycle's expected outputs
  task automatic step(input logic r, input logic h, input logic c, input logic [3:0] t,
                      input logic [1:0] a1, input logic [1:0] b1, input logic s1, input logic f1,
                      input logic [1:0] a3, input logic [1:0] b3, input logic s3, input logic f3);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; hz_hold = h; hz_conf = c; hz_type = t;
    step_no++;
    e.stp = step_no;
    e.e1  = {a1, b1, s1, f1};
    e.e3  = {a3, b3, s3, f3};
`ifdef HZ_STALL_CNT_EN
    e.c1 = m1;
    e.c3 = m3;
`else
    e.c1 = 0;
    e.c3 = 0;
`endif
    exp_q.push_back(e);
    if (r) begin
      m1 = 0;
      m3 = 0;
    end else begin
      if (f1 && m1 < 65535) m1++;
      if (f3 && m3 < 15) m3++;
    end
  endtask

  // Monitor: compare the DUT outputs against the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("d1_fwd_a",   e.stp, 32'(d1_fa),  32'(e.e1[5:4]));
        chk("d1_fwd_b",   e.stp, 32'(d1_fb),  32'(e.e1[3:2]));
        chk("d1_stall_f", e.stp, 32'(d1_sf),  32'(e.e1[1]));
        chk("d1_stall_d", e.stp, 32'(d1_sd),  32'(e.e1[1]));
        chk("d1_flush_e", e.stp, 32'(d1_fe),  32'(e.e1[0]));
        chk("d1_cnt",     e.stp, 32'(d1_cnt), 32'(e.c1));
        chk("d3_fwd_a",   e.stp, 32'(d3_fa),  32'(e.e3[5:4]));
        chk("d3_fwd_b",   e.stp, 32'(d3_fb),  32'(e.e3[3:2]));
        chk("d3_stall_f", e.stp, 32'(d3_sf),  32'(e.e3[1]));
        chk("d3_stall_d", e.stp, 32'(d3_sd),  32'(e.e3[1]));
        chk("d3_flush_e", e.stp, 32'(d3_fe),  32'(e.e3[0]));
        chk("d3_cnt",     e.stp, 32'(d3_cnt), 32'(e.c3));
      end
    end
  end

  initial begin
    rst = 1'b1; hz_hold = 1'b0; hz_conf = 1'b0; hz_type = 4'd0;
    repeat (2) @(posedge clk);

    // reset state
    step(0,0,0,4'd0,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    // forwarding decode, one-cycle latency
    step(0,0,1,4'd1,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    step(0,0,0,4'd0,  2'b01,2'b00,0,0,  2'b01,2'b00,0,0);
    step(0,0,1,4'd2,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    step(0,0,1,4'd5,  2'b00,2'b01,0,0,  2'b00,2'b01,0,0);
    step(0,0,1,4'd8,  2'b10,2'b00,0,0,  2'b10,2'b00,0,0);
    step(0,0,0,4'd1,  2'b00,2'b10,0,0,  2'b00,2'b10,0,0);
    step(0,0,1,4'd12, 2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    step(0,0,1,4'd7,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    step(0,0,1,4'd6,  2'b10,2'b00,0,0,  2'b10,2'b00,0,0);
    // load-use rt; d1 one bubble, d3 three bubbles; d1 back-to-back on rs
    step(0,0,1,4'd4,  2'b00,2'b10,1,1,  2'b00,2'b10,1,1);
    step(0,0,1,4'd1,  2'b00,2'b00,0,0,  2'b00,2'b00,1,1);
    step(0,0,1,4'd3,  2'b00,2'b10,1,1,  2'b00,2'b00,1,1);
    step(0,0,1,4'd2,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    step(0,0,0,4'd0,  2'b10,2'b00,0,0,  2'b00,2'b10,0,0);
    step(0,0,0,4'd0,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    // hold for two cycles mid-stall
    step(0,0,1,4'd3,  2'b00,2'b00,1,1,  2'b00,2'b00,1,1);
    step(0,1,1,4'd5,  2'b00,2'b00,1,0,  2'b00,2'b00,1,0);
    step(0,1,0,4'd0,  2'b00,2'b00,1,0,  2'b00,2'b00,1,0);
    step(0,0,1,4'd8,  2'b00,2'b00,0,0,  2'b00,2'b00,1,1);
    step(0,0,0,4'd0,  2'b10,2'b00,0,0,  2'b00,2'b00,1,1);
    step(0,0,0,4'd0,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    step(0,0,0,4'd0,  2'b00,2'b00,0,0,  2'b10,2'b00,0,0);
    step(0,0,0,4'd0,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    // hold in RUN freezes the selects
    step(0,0,1,4'd1,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    step(0,1,1,4'd2,  2'b01,2'b00,1,0,  2'b01,2'b00,1,0);
    step(0,0,0,4'd0,  2'b01,2'b00,0,0,  2'b01,2'b00,0,0);
    // reset mid-stall (overrides hold), then an out-of-range code
    step(0,0,1,4'd4,  2'b00,2'b00,1,1,  2'b00,2'b00,1,1);
    step(1,1,1,4'd3,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    step(0,0,1,4'd12, 2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    step(0,0,0,4'd0,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);
    // repeated load-use hazards; d3 counter saturates at 15
    for (int i = 0; i < 6; i++) begin
      step(0,0,1,4'd3, 2'b00,2'b00,1,1, (i == 0) ? 2'b00 : 2'b10,2'b00,1,1);
      step(0,0,1,4'd1, 2'b00,2'b00,0,0, 2'b00,2'b00,1,1);
      step(0,0,0,4'd0, 2'b10,2'b00,0,0, 2'b00,2'b00,1,1);
      step(0,0,0,4'd0, 2'b00,2'b00,0,0, 2'b00,2'b00,0,0);
    end
    step(0,0,0,4'd0,  2'b00,2'b00,0,0,  2'b10,2'b00,0,0);
    step(0,0,0,4'd0,  2'b00,2'b00,0,0,  2'b00,2'b00,0,0);

    // let the monitor drain the queue, bounded
    for (int k = 0; k < 20 && exp_q.size() > 0; k++) @(posedge clk);
    @(posedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain pending %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
